rsa_modexp_core: RTL and testbench
==================================

Name: rsa_modexp_core

Overview:
Parametrised, fully synchronous successor to the 256-bit RSA decryption core. It computes o_result = i_base^i_exp mod i_mod for odd moduli of configurable WIDTH, using bit-serial Montgomery multiplication with one iteration per clock. It sits between the RSA wrapper (operand loading, Avalon/UART side) and the key/cipher registers. Two Montgomery datapaths (square and multiply) run in lockstep.

Parameters:
WIDTH, 256, operand width in bits (base, exponent, modulus, result); legal range 8..1024.
CNT_W, $clog2(WIDTH+1), width of the internal iteration counters.

Ports:
i_clk  input  1  clock; all state changes on rising edge only.
i_rst  input  1  asynchronous, active-high reset.
i_start  input  1  start request; accepted only in S_IDLE.
i_base  input  WIDTH  base a; caller guarantees a < N.
i_exp  input  WIDTH  exponent d.
i_mod  input  WIDTH  modulus N; caller guarantees N odd and N > 1.
o_busy  output  1  high from the cycle after acceptance until o_finished.
o_finished  output  1  one-cycle pulse; o_result is valid in the same cycle.
o_result  output  WIDTH  a^d mod N; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state): state=S_IDLE, o_busy=0, o_finished=0, o_result=0, all operand and work registers=0.
- On acceptance (S_IDLE and i_start=1): latch i_base, i_exp and i_mod into internal registers. Later input changes have no effect.
  - Initialise m=1, t=a, k=0 (exponent bit index), go to S_PREP.
- i_start in any state other than S_IDLE is ignored. It causes no restart and no error.
- S_PREP, WIDTH cycles: each cycle t = 2t; if t >= N then t = t - N.
  - Use a WIDTH+1-bit intermediate.
  - On exit t = a*2^WIDTH mod N (Montgomery form). Go to S_MONT.
- S_MONT: a bit-serial Montgomery product over WIDTH cycles, iteration index j=0..WIDTH-1.
  - Accumulators are WIDTH+2 bits and are cleared on entry.
  - Square accumulator: if t[j], s += t; if s odd, s += N; s >>= 1.
  - Multiply accumulator: if t[j], p += m; if p odd, p += N; p >>= 1. This only matters when d[k]=1, but it always runs for a fixed cycle count.
  - Go to S_CORR.
- S_CORR, 1 cycle:
  - t' = (s >= N) ? s-N : s.
  - If d[k]=1, m' = (p >= N) ? p-N : p; otherwise m is unchanged.
  - Update t and m. If k == last index, go to S_DONE; otherwise k++ and go to S_MONT.
- Because m starts at 1 in normal form and t is in Montgomery form, m stays in normal form. No post-conversion is needed.
- S_DONE, 1 cycle: o_result=m, o_finished=1, o_busy=0, go to S_IDLE.
- Latency from the acceptance edge to the o_finished cycle is WIDTH + WIDTH*(WIDTH+1) + 1 cycles, with last index = WIDTH-1.
- d=0 yields 1. a=0 with d>0 yields 0.
- Back-to-back operation: i_start high in the cycle after o_finished is accepted, with no dead cycle.
- Reset asserted mid-operation aborts immediately. o_finished does not pulse.

Optional Feature:
RSA_EXP_SKIP_EN
- Defined: at acceptance, compute h = index of the highest set bit of d.
  - The last index becomes h, so latency is WIDTH + (h+1)*(WIDTH+1) + 1.
  - If d=0, go from S_PREP directly to S_DONE with result 1.
  - Results are identical to the undefined build.
- Undefined: all WIDTH exponent bits are always processed, giving fixed, data-independent latency (timing-attack safe).

Test Plan:
1. WIDTH=8, N=0xB3, a=0x05, d=0x03 -> o_result=0x7D. Without the macro, o_finished occurs exactly 81 cycles after acceptance; o_busy is high throughout.
2. WIDTH=16, N=0xFFF1, a=0x0002, d=0x0010 -> o_result=0x000F. With RSA_EXP_SKIP_EN, latency is 16+5*17+1=102.
3. WIDTH=8, N=0xB3: d=0x00 -> 0x01; d=0x01, a=0xB2 -> 0xB2; a=0x00, d=0x07 -> 0x00.
4. WIDTH=8: pulse i_start with new operands while busy -> ignored; the result matches the first operands. Then restart in the cycle after o_finished -> second result correct.
5. Assert i_rst for 1 cycle mid-S_MONT -> o_busy=0, o_result=0, no o_finished pulse. A subsequent start computes correctly.
6. WIDTH=256: 20 random odd N with a < N and random d -> o_result matches reference pow(a,d,N) for every vector.

Source files
------------

// File: rtl/rsa_modexp_core.sv
// -----------------------------------------------------------------------------
// rsa_modexp_core
//   Modular exponentiation o_result = i_base^i_exp mod i_mod for odd moduli,
//   using right-to-left binary exponentiation with two bit-serial Montgomery
//   datapaths (square and multiply) that run in lockstep, one iteration per
//   clock.
//
// Parameters
//   WIDTH  operand width in bits (8..1024)
//   CNT_W  iteration counter width
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_start     start request, accepted only when idle
//   i_base      base a (a < N)
//   i_exp       exponent d
//   i_mod       modulus N (odd, N > 1)
//   o_busy      high while an operation is in flight
//   o_finished  one-cycle pulse, o_result valid in the same cycle
//   o_result    a^d mod N, held until the next accepted start
//
// Build option
//   RSA_EXP_SKIP_EN  when defined, exponent bits above the highest set bit are
//                    skipped (data-dependent latency). When undefined, all
//                    WIDTH exponent bits are always processed.
// -----------------------------------------------------------------------------
module rsa_modexp_core #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_base,
    input  logic [WIDTH-1:0] i_exp,
    input  logic [WIDTH-1:0] i_mod,
    output logic             o_busy,
    output logic             o_finished,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned AW = WIDTH + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MONT,
        S_CORR,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             fin_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] exp_q;     // shifted right once per exponent bit
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] t_q;       // running square, Montgomery form
    logic [WIDTH-1:0] m_q;       // running product, normal form
    logic [AW-1:0]    s_q;       // square accumulator
    logic [AW-1:0]    p_q;       // multiply accumulator
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] k_q;

    logic [CNT_W-1:0] last_idx_c;
    logic             skip_all_c;

`ifdef RSA_EXP_SKIP_EN
    logic [CNT_W-1:0] last_q;
    logic             zero_q;
    logic [CNT_W-1:0] h_c;

    // Index of the highest set exponent bit, taken from the live input.
    always_comb begin
        h_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i_exp[i]) h_c = CNT_W'(i);
        end
    end

    assign last_idx_c = last_q;
    assign skip_all_c = zero_q;
`else
    assign last_idx_c = CNT_LAST;
    assign skip_all_c = 1'b0;
`endif

    logic [WIDTH:0]   t2;
    logic             t_bit;
    logic [AW-1:0]    n_ext;
    logic [AW-1:0]    s_sum;
    logic [AW-1:0]    p_sum;
    logic [AW-1:0]    s_d;
    logic [AW-1:0]    p_d;
    logic [WIDTH-1:0] t_prep_d;
    logic [WIDTH-1:0] t_corr_d;
    logic [WIDTH-1:0] m_corr_d;

    // Datapath: doubling step, Montgomery iterations and final corrections.
    always_comb begin
        n_ext    = AW'(mod_q);
        t2       = {t_q, 1'b0};
        t_prep_d = WIDTH'((t2 >= {1'b0, mod_q}) ? t2 - {1'b0, mod_q} : t2);

        // Multiplier bit t[j] selected by the iteration counter.
        t_bit = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (cnt_q == CNT_W'(i)) t_bit = t_q[i];
        end

        s_sum = s_q + (t_bit ? AW'(t_q) : '0);
        s_d   = (s_sum[0] ? s_sum + n_ext : s_sum) >> 1;
        p_sum = p_q + (t_bit ? AW'(m_q) : '0);
        p_d   = (p_sum[0] ? p_sum + n_ext : p_sum) >> 1;

        // Accumulators end below 2N, so one subtraction suffices.
        t_corr_d = WIDTH'((s_q >= n_ext) ? s_q - n_ext : s_q);
        m_corr_d = WIDTH'((p_q >= n_ext) ? p_q - n_ext : p_q);
    end

    // Control FSM and state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
            result_q <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            t_q      <= '0;
            m_q      <= '0;
            s_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
`ifdef RSA_EXP_SKIP_EN
            last_q   <= '0;
            zero_q   <= 1'b0;
`endif
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        exp_q   <= i_exp;
                        mod_q   <= i_mod;
                        t_q     <= i_base;
                        m_q     <= WIDTH'(1);
                        cnt_q   <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
`ifdef RSA_EXP_SKIP_EN
                        last_q  <= h_c;
                        zero_q  <= (i_exp == '0);
`endif
                    end
                end
                S_PREP: begin
                    t_q <= t_prep_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        s_q     <= '0;
                        p_q     <= '0;
                        state_q <= skip_all_c ? S_DONE : S_MONT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_MONT: begin
                    s_q <= s_d;
                    p_q <= p_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_CORR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CORR: begin
                    t_q <= t_corr_d;
                    if (exp_q[0]) m_q <= m_corr_d;
                    exp_q <= exp_q >> 1;
                    if (k_q == last_idx_c) begin
                        state_q <= S_DONE;
                    end else begin
                        k_q     <= k_q + CNT_W'(1);
                        s_q     <= '0;
                        p_q     <= '0;
                        state_q <= S_MONT;
                    end
                end
                S_DONE: begin
                    result_q <= m_q;
                    fin_q    <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_finished = fin_q;
    assign o_result   = result_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// -----------------------------------------------------------------------------
// tb_rsa_modexp_core
//   Directed bench for rsa_modexp_core at WIDTH=8 and WIDTH=16, with a small
//   square-and-multiply reference for a handful of extra vectors.
// -----------------------------------------------------------------------------
module tb_rsa_modexp_core;

    logic clk;
    logic rst;

    logic       st8, busy8, fin8;
    logic [7:0] a8, d8, n8, res8;

    logic        st16, busy16, fin16;
    logic [15:0] a16, d16, n16, res16;

    int n_chk;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rsa_modexp_core #(.WIDTH(8)) u_dut8 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (st8),
        .i_base     (a8),
        .i_exp      (d8),
        .i_mod      (n8),
        .o_busy     (busy8),
        .o_finished (fin8),
        .o_result   (res8)
    );

    rsa_modexp_core #(.WIDTH(16)) u_dut16 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (st16),
        .i_base     (a16),
        .i_exp      (d16),
        .i_mod      (n16),
        .o_busy     (busy16),
        .o_finished (fin16),
        .o_result   (res16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] modpow(input logic [31:0] a, input logic [31:0] d,
                                           input logic [31:0] n);
        longint unsigned r;
        longint unsigned b;
        r = 1;
        b = longint'(a) % longint'(n);
        for (int i = 0; i < 32; i++) begin
            if (d[i]) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
        end
        return 32'(r);
    endfunction

    function automatic int exp_lat(input int w, input logic [31:0] d);
`ifdef RSA_EXP_SKIP_EN
        int h;
        h = -1;
        for (int i = 0; i < w; i++) if (d[i]) h = i;
        if (h < 0) return w + 1;
        return w + (h + 1) * (w + 1) + 1;
`else
        return w + w * (w + 1) + 1 + 0 * int'(d[0]);
`endif
    endfunction

    // Caller is #1 after a rising edge; acceptance happens on the next edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] d, input logic [7:0] n);
        st8 = 1'b1; a8 = a; d8 = d; n8 = n;
        @(posedge clk); #1;
        st8 = 1'b0; a8 = ~a; d8 = ~d; n8 = ~n;
    endtask

    task automatic wait8(output logic [7:0] res, output int lat, output logic busy_ok);
        logic done;
        done    = 1'b0;
        lat     = 0;
        busy_ok = busy8;
        while (!done && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            if (fin8) begin
                done = 1'b1;
                if (busy8) busy_ok = 1'b0;
            end else if (!busy8) begin
                busy_ok = 1'b0;
            end
        end
        if (!done) check("timeout8", 32'(done), 32'd1);
        res = res8;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] d, input logic [15:0] n);
        st16 = 1'b1; a16 = a; d16 = d; n16 = n;
        @(posedge clk); #1;
        st16 = 1'b0; a16 = ~a; d16 = ~d; n16 = ~n;
    endtask

    task automatic wait16(output logic [15:0] res, output int lat, output logic busy_ok);
        logic done;
        done    = 1'b0;
        lat     = 0;
        busy_ok = busy16;
        while (!done && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            if (fin16) begin
                done = 1'b1;
                if (busy16) busy_ok = 1'b0;
            end else if (!busy16) begin
                busy_ok = 1'b0;
            end
        end
        if (!done) check("timeout16", 32'(done), 32'd1);
        res = res16;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] n, input logic [7:0] exp);
        logic [7:0] r;
        int         lat;
        logic       bok;
        start8(a, d, n);
        wait8(r, lat, bok);
        check(tag, 32'(r), 32'(exp));
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] n, input logic [15:0] exp);
        logic [15:0] r;
        int          lat;
        logic        bok;
        start16(a, d, n);
        wait16(r, lat, bok);
        check(tag, 32'(r), 32'(exp));
    endtask

    initial begin
        logic [7:0]  r8;
        logic [15:0] r16;
        int          lat;
        logic        bok;
        logic        seen;
        logic [31:0] rn, ra, rd;

        n_chk = 0;
        n_bad = 0;
        rst  = 1'b1;
        st8  = 1'b0; a8  = '0; d8  = '0; n8  = '0;
        st16 = 1'b0; a16 = '0; d16 = '0; n16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy8",  32'(busy8), 32'd0);
        check("rst_fin8",   32'(fin8),  32'd0);
        check("rst_res8",   32'(res8),  32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_res16",  32'(res16), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 5^3 mod 179, with latency and busy profile
        start8(8'h05, 8'h03, 8'hB3);
        check("t1_busy_after_accept", 32'(busy8), 32'd1);
        wait8(r8, lat, bok);
        check("t1_result", 32'(r8), 32'h7D);
        check("t1_latency", 32'(lat), 32'(exp_lat(8, 32'h03)));
        check("t1_busy_profile", 32'(bok), 32'd1);

        // 2^16 mod 65521
        start16(16'h0002, 16'h0010, 16'hFFF1);
        wait16(r16, lat, bok);
        check("t2_result", 32'(r16), 32'h000F);
        check("t2_latency", 32'(lat), 32'(exp_lat(16, 32'h10)));
        check("t2_busy_profile", 32'(bok), 32'd1);

        // Boundary exponents and bases
        run8("t3_d0",    8'h05, 8'h00, 8'hB3, 8'h01);
        run8("t3_d1",    8'hB2, 8'h01, 8'hB3, 8'hB2);
        run8("t3_a0",    8'h00, 8'h07, 8'hB3, 8'h00);
        run8("t3_pow28", 8'h02, 8'h08, 8'hB3, 8'h4D);
        run16("t3_small_n", 16'h0003, 16'h0005, 16'h000D, 16'h0009);
        run16("t3_d0_16",   16'h1234, 16'h0000, 16'hFFF1, 16'h0001);

        // Start while busy is ignored; then back-to-back restart
        start8(8'h05, 8'h03, 8'hB3);
        repeat (20) @(posedge clk);
        #1;
        st8 = 1'b1; a8 = 8'h11; d8 = 8'h05; n8 = 8'h0F;
        @(posedge clk); #1;
        st8 = 1'b0;
        wait8(r8, lat, bok);
        check("t4_ignore_start", 32'(r8), 32'h7D);
        check("t4_ignore_latency", 32'(lat), 32'(exp_lat(8, 32'h03) - 21));
        start8(8'h07, 8'h0A, 8'hB3);
        check("t4_b2b_accept", 32'(busy8), 32'd1);
        wait8(r8, lat, bok);
        check("t4_b2b_result", 32'(r8), 32'h03);

        // Reset mid-operation aborts without a finish pulse
        start8(8'h05, 8'h03, 8'hB3);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_busy_async", 32'(busy8), 32'd0);
        check("t5_res_async",  32'(res8),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (fin8 || busy8) seen = 1'b1;
        end
        check("t5_no_finish", 32'(seen), 32'd0);
        run8("t5_after_reset", 8'h05, 8'h03, 8'hB3, 8'h7D);

        // Extra vectors against the reference model
        for (int v = 0; v < 6; v++) begin
            rn = 32'($urandom_range(3, 255)) | 32'd1;
            ra = 32'($urandom) % rn;
            rd = 32'($urandom_range(0, 255));
            run8("rnd8", 8'(ra), 8'(rd), 8'(rn), 8'(modpow(ra, rd, rn)));
        end
        for (int v = 0; v < 8; v++) begin
            rn = 32'($urandom_range(3, 65535)) | 32'd1;
            ra = 32'($urandom) % rn;
            rd = 32'($urandom_range(0, 65535));
            run16("rnd16", 16'(ra), 16'(rd), 16'(rn), 16'(modpow(ra, rd, rn)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
